dmem_lsu: RTL
=============

// Module: dmem_lsu
// PURPOSE
//  Load/store unit on the requester side of the four byte-lane dmem instances
//  (lanes 0..3, each with a synchronous read of one cycle and a synchronous write).
//  Takes RV32 load/store requests from the core and drives the shared mem_addr and
//  the per-lane mem_we/mem_wdata. Merges, shifts and sign/zero-extends the lane read
//  data into a 32-bit response. Word-crossing misaligned accesses are optionally
//  split into two back-to-back word accesses.
// PARAMETERS
//  (none; dmem data width 8b/lane and 4 lanes are fixed)
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst_n        in   1   synchronous, active-low reset
//  req_valid    in   1   request present
//  req_ready    out  1   LSU can accept; accept = req_valid & req_ready
//  req_we       in   1   1 = store, 0 = load
//  req_funct3   in   3   RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr     in   32  byte address
//  req_wdata    in   32  store data (rs2)
//  rsp_valid    out  1   one-cycle response pulse (loads and stores); no backpressure
//  rsp_rdata    out  32  load result, extended; 0 for stores/errors/when !rsp_valid
//  rsp_err      out  1   access rejected (illegal funct3 / misaligned without split)
//  mem_addr     out  32  address to all lanes (lanes index with addr[12:2])
//  mem_we       out  4   per-lane write enable, bit i -> lane i
//  mem_wdata    out  32  lane i data on [8i+7:8i]
//  mem_rdata    in   32  lane i rd_data on [8i+7:8i]; valid the cycle after mem_addr
// BEHAVIOUR
//  - Byte at address A is held in lane A[1:0]; off = req_addr[1:0]; W = {req_addr[31:2],2'b00}.
//  - Reset (rst_n=0 at posedge): state=IDLE. While rst_n=0: req_ready=0, mem_we=0,
//    rsp_valid=0, rsp_err=0, rsp_rdata=0. Next cycle: req_ready=1.
//  - States: IDLE (req_ready=1), SPLIT (req_ready=0). No other states.
//  - IDLE accept at cycle T, single access: mem_addr=W, mem_we/mem_wdata driven
//    combinationally in cycle T. rsp_valid=1 at T+1, rsp_rdata from mem_rdata at T+1.
//    A new request is accepted in T+1 (full throughput, 1 request/cycle).
//  - Store lanes: SB we=1<<off, data req_wdata[7:0] on lane off; SH we=3<<off, lanes
//    off,off+1 = wdata[7:0],[15:8]; SW we=4'b1111. Lanes with we=0 are don't-care.
//  - Load: byte/half extracted from lane off upward. B/H sign-extend, BU/HU zero-extend.
//  - Illegal funct3 (011,110,111; 100/101 with req_we=1): no access (mem_we=0),
//    rsp_valid=1, rsp_err=1, rsp_rdata=0 at T+1.
//  - Crossing: H with off=3; W with off!=0. Within-word misaligned: H with off=1.
//  - Split (crossing, feature on): T: access W, lanes off..3 (low part);
//    T+1 in SPLIT: mem_addr=W+4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000),
//    lanes 0..n-1 (high part); low-part read data captured in a register at T+1;
//    rsp_valid at T+2 with merged result; state back to IDLE at T+2.
//  - Reset during SPLIT: split abandoned, no response ever issued, low-part write
//    at T remains committed in memory.
//  - rsp_valid is never asserted in two consecutive cycles for the same request.
// CONFIGURATION
//  MISALIGN_SPLIT_EN defined: within-word misaligned accesses take one access;
//   crossing ones take the two-cycle split above; rsp_err only for illegal funct3.
//  MISALIGN_SPLIT_EN undefined: any access not naturally aligned (H: off[0]!=0,
//   W: off!=0) is rejected: mem_we=0, rsp_err=1, rsp_rdata=0 at T+1; SPLIT state unused.
// TESTING
//  1 SW 0xDEADBEEF @0x100, then LW @0x100 -> mem_we=1111 at store; rsp_rdata=0xDEADBEEF at T+1.
//  2 mem @0x100=0xDE332211: LB @0x103 -> 0xFFFFFFDE; LBU -> 0x000000DE; LH @0x102 -> 0xFFFFDE33.
//  3 SH 0x00001234 @0x102 -> mem_addr=0x100, mem_we=1100, mem_wdata[31:16]=0x1234, rsp_err=0.
//  4 EN: mem 0x100=0x44332211, 0x104=0x88776655; LW @0x101 -> req_ready=0 at T+1,
//    mem_addr 0x100 then 0x104, rsp at T+2 = 0x55443322. Not EN: rsp_err=1 at T+1, no access.
//  5 EN: SW 0xAABBCCDD @0x103 -> T: addr 0x100 we=1000 lane3=DD; T+1: addr 0x104 we=0111
//    lanes0..2=CC,BB,AA; rsp_valid at T+2. @0xFFFFFFFF the second access goes to 0x00000000.
//  6 EN: LW @0x102, rst_n=0 at T+1 -> no rsp_valid ever; req_ready=1 the cycle after reset.

Source files
------------

// File: rtl/dmem_lsu.sv
// Load/store unit driving four byte-lane dmem instances; merges and extends lane read data.
// Optional MISALIGN_SPLIT_EN: word-crossing accesses become two back-to-back word accesses.
//
// state   | meaning
// S_IDLE  | ready for a request; single accesses and the low part of a split issue here
// S_SPLIT | issuing the high part of a word-crossing access at the next word address
module dmem_lsu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {S_IDLE = 1'b0, S_SPLIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [1:0]  off;
    logic [31:0] word_addr;
    logic [3:0]  size_mask;
    logic [7:0]  be_wide;
    logic [63:0] wdata_wide;
    logic        illegal;
    logic        reject;
    logic        split;
    logic        accept;

    logic        rsp_pend_q;
    logic        rsp_err_q;
    logic        rsp_load_q;
    logic        rsp_merged_q;
    logic [2:0]  rsp_funct3_q;
    logic [1:0]  rsp_off_q;
    logic [31:0] lo_q;
    logic [31:0] hi_addr_q;
    logic [3:0]  hi_we_q;
    logic [31:0] hi_wdata_q;

    logic [63:0] rd_wide;
    logic [31:0] rd_aligned;
    logic [31:0] rd_ext;

    assign off       = req_addr[1:0];
    assign word_addr = {req_addr[31:2], 2'b00};

    always_comb begin
        size_mask = 4'b1111;
        case (req_funct3[1:0])
            2'b00:   size_mask = 4'b0001;
            2'b01:   size_mask = 4'b0011;
            default: size_mask = 4'b1111;
        endcase
    end

    // Byte enables and store data laid out over two consecutive words.
    assign be_wide    = {4'b0000, size_mask} << off;
    assign wdata_wide = {32'h0, req_wdata} << {off, 3'b000};

    assign illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_funct3[2] && req_we);

`ifdef MISALIGN_SPLIT_EN
    logic crossing;
    assign crossing = |be_wide[7:4];
    assign reject   = illegal;
    assign split    = !illegal && crossing;
`else
    logic misaligned;
    assign misaligned = ((req_funct3[1:0] == 2'b01) && off[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (off != 2'b00));
    assign reject     = illegal || misaligned;
    assign split      = 1'b0;
`endif

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d   = state_q;
        req_ready = rst_n && (state_q == S_IDLE);
        mem_addr  = word_addr;
        mem_we    = 4'b0000;
        mem_wdata = wdata_wide[31:0];
        case (state_q)
            S_IDLE: begin
                if (accept && !reject) begin
                    mem_we = req_we ? be_wide[3:0] : 4'b0000;
                    if (split)
                        state_d = S_SPLIT;
                end
            end
            S_SPLIT: begin
                mem_addr  = hi_addr_q;
                mem_we    = hi_we_q;
                mem_wdata = hi_wdata_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!rst_n)
            mem_we = 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rsp_pend_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_load_q   <= 1'b0;
            rsp_merged_q <= 1'b0;
            rsp_funct3_q <= 3'b000;
            rsp_off_q    <= 2'b00;
            lo_q         <= 32'h0;
            hi_addr_q    <= 32'h0;
            hi_we_q      <= 4'b0000;
            hi_wdata_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            rsp_pend_q <= 1'b0;
            if (state_q == S_IDLE && accept) begin
                rsp_pend_q   <= !split;
                rsp_err_q    <= reject;
                rsp_load_q   <= !req_we;
                rsp_merged_q <= split;
                rsp_funct3_q <= req_funct3;
                rsp_off_q    <= off;
                hi_addr_q    <= word_addr + 32'd4;
                hi_we_q      <= req_we ? be_wide[7:4] : 4'b0000;
                hi_wdata_q   <= wdata_wide[63:32];
            end
            if (state_q == S_SPLIT) begin
                lo_q       <= mem_rdata;
                rsp_pend_q <= 1'b1;
            end
        end
    end

    // Low word was captured in the split cycle; the high word is on mem_rdata now.
    assign rd_wide    = rsp_merged_q ? {mem_rdata, lo_q} : {32'h0, mem_rdata};
    assign rd_aligned = 32'(rd_wide >> {rsp_off_q, 3'b000});

    always_comb begin
        rd_ext = 32'h0;
        case (rsp_funct3_q)
            3'b000:  rd_ext = {{24{rd_aligned[7]}}, rd_aligned[7:0]};
            3'b001:  rd_ext = {{16{rd_aligned[15]}}, rd_aligned[15:0]};
            3'b010:  rd_ext = rd_aligned;
            3'b100:  rd_ext = {24'h0, rd_aligned[7:0]};
            3'b101:  rd_ext = {16'h0, rd_aligned[15:0]};
            default: rd_ext = 32'h0;
        endcase
    end

    assign rsp_valid = rst_n && rsp_pend_q;
    assign rsp_err   = rsp_valid && rsp_err_q;
    assign rsp_rdata = (rsp_valid && rsp_load_q && !rsp_err_q) ? rd_ext : 32'h0;

endmodule
